rw_write_arb: RTL

Arbitrates the data-array write port among N writer units (write_rw instances of several cores plus the undo-log restore path) onto a single registered wvalid/waddr/wdata/wstrb channel. Undo-log-restore requests take priority over normal writes, bounded by a starvation limit. Writes to the same line address while the output register is stalled are coalesced byte-wise. Sits between the per-core write_rw outputs and the L2 data-array write port.

---
 rtl/rw_write_arb_pkg.sv | 38 +++
 rtl/rw_write_arb_rr_pick.sv | 42 ++++
 rtl/rw_write_arb.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rw_write_arb_pkg.sv
// ---------------------------------------------------------------------------
// rw_write_arb_pkg
// Shared definitions for the data-array write arbiter: the per-port write
// request bundle, line geometry constants, the default starvation limit and
// the byte-wise merge helper used when coalescing writes to a stalled line.
// ---------------------------------------------------------------------------
package rw_write_arb_pkg;

    localparam int RW_LINE_BYTES       = 64;
    localparam int RW_ADDR_W           = 32;
    localparam int RW_DATA_W           = RW_LINE_BYTES * 8;
    localparam int RW_ARB_STARVE_LIMIT = 15;

    typedef struct packed {
        logic [RW_ADDR_W-1:0]     addr;
        logic [RW_DATA_W-1:0]     data;
        logic [RW_LINE_BYTES-1:0] strb;
        logic                     prio;
    } rw_wr_req_t;

    // Overwrite each byte of i_old whose strobe bit is set with the byte
    // from i_new; unstrobed bytes keep their previous value.
    function automatic logic [RW_DATA_W-1:0] rw_merge_bytes(
        input logic [RW_DATA_W-1:0]     i_old,
        input logic [RW_DATA_W-1:0]     i_new,
        input logic [RW_LINE_BYTES-1:0] i_strb
    );
        logic [RW_DATA_W-1:0] v_res;
        v_res = i_old;
        for (int b = 0; b < RW_LINE_BYTES; b++) begin
            if (i_strb[b]) begin
                v_res[b*8 +: 8] = i_new[b*8 +: 8];
            end
        end
        return v_res;
    endfunction

endpackage

// File: rtl/rw_write_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational N-way round-robin picker. Searches the request vector
// starting at the pointer position and wrapping; the first set bit wins.
// Ports:
//   i_req  N   request vector
//   i_ptr  IW  index with the highest priority this cycle
//   o_gnt  N   one-hot grant (zero when no request)
//   o_idx  IW  index of the granted request (0 when none)
//   o_any  1   at least one request is present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        logic [IW-1:0] v_cand;
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        v_cand = '0;
        // N is a power of two, so the IW-bit add wraps naturally.
        for (int k = 0; k < N; k++) begin
            v_cand = i_ptr + IW'(k);
            if (!o_any && i_req[v_cand]) begin
                o_any = 1'b1;
                o_idx = v_cand;
            end
        end
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rw_write_arb.sv
// ---------------------------------------------------------------------------
// rw_write_arb
// Arbitrates the L2 data-array write port among N_PORTS writers (core
// write units plus the undo-log restore path) onto one registered
// wvalid/waddr/wdata/wstrb channel. Undo-log restores (high class) win over
// normal writes unless a normal writer has been passed over STARVE_LIMIT
// times in a row. While the output register is stalled, a winner targeting
// the same line is merged byte-wise into it instead of waiting.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   i_req_valid  N   per-port request
//   i_req_prio   N   request is an undo-log restore
//   i_req_addr   N*32  line address per port (port p at [p*32 +: 32])
//   i_req_data   N*512 write data per port
//   i_req_strb   N*64  byte enables per port
//   o_req_ready  N   one-hot/zero accept, combinational
//   o_wvalid/i_wready  write handshake to the data array
//   o_waddr/o_wdata/o_wstrb  registered write payload
//   o_wport      port id of the latest load or merge
//   o_merge_count  saturating count of coalesced writes
// ---------------------------------------------------------------------------
module rw_write_arb
    import rw_write_arb_pkg::*;
#(
    parameter int N_PORTS      = 4,
    parameter int STARVE_LIMIT = RW_ARB_STARVE_LIMIT,
    parameter int PW           = $clog2(N_PORTS)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_PORTS-1:0]             i_req_valid,
    input  logic [N_PORTS-1:0]             i_req_prio,
    input  logic [N_PORTS*RW_ADDR_W-1:0]   i_req_addr,
    input  logic [N_PORTS*RW_DATA_W-1:0]   i_req_data,
    input  logic [N_PORTS*RW_LINE_BYTES-1:0] i_req_strb,
    output logic [N_PORTS-1:0]             o_req_ready,
    output logic                           o_wvalid,
    input  logic                           i_wready,
    output logic [RW_ADDR_W-1:0]           o_waddr,
    output logic [RW_DATA_W-1:0]           o_wdata,
    output logic [RW_LINE_BYTES-1:0]       o_wstrb,
    output logic [PW-1:0]                  o_wport,
    output logic [31:0]                    o_merge_count
);

    localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

    // Output register and arbitration state
    logic                     r_wvalid;
    logic [RW_ADDR_W-1:0]     r_waddr;
    logic [RW_DATA_W-1:0]     r_wdata;
    logic [RW_LINE_BYTES-1:0] r_wstrb;
    logic [PW-1:0]            r_wport;
    logic [31:0]              r_merge_count;
    logic [PW-1:0]            r_ptr_hi;
    logic [PW-1:0]            r_ptr_lo;
    logic [7:0]               r_starve_cnt;

    rw_wr_req_t               w_req [N_PORTS];
    rw_wr_req_t               w_win;
    logic [N_PORTS-1:0]       w_hi_req;
    logic [N_PORTS-1:0]       w_lo_req;
    logic [N_PORTS-1:0]       w_hi_gnt;
    logic [N_PORTS-1:0]       w_lo_gnt;
    logic [PW-1:0]            w_hi_idx;
    logic [PW-1:0]            w_lo_idx;
    logic                     w_hi_any;
    logic                     w_lo_any;
    logic                     w_use_hi;
    logic [PW-1:0]            w_win_idx;
    logic                     w_win_any;
    logic                     w_free;
    logic                     w_load;
    logic                     w_merge;
    logic                     w_accept;

    // Unpack the flat request buses into per-port bundles.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            w_req[p].addr = i_req_addr[p*RW_ADDR_W +: RW_ADDR_W];
            w_req[p].data = i_req_data[p*RW_DATA_W +: RW_DATA_W];
            w_req[p].strb = i_req_strb[p*RW_LINE_BYTES +: RW_LINE_BYTES];
            w_req[p].prio = i_req_prio[p];
        end
    end

    assign w_hi_req = i_req_valid & i_req_prio;
    assign w_lo_req = i_req_valid & ~i_req_prio;

    rr_pick #(.N(N_PORTS), .IW(PW)) u_pick_hi (
        .i_req (w_hi_req),
        .i_ptr (r_ptr_hi),
        .o_gnt (w_hi_gnt),
        .o_idx (w_hi_idx),
        .o_any (w_hi_any)
    );

    rr_pick #(.N(N_PORTS), .IW(PW)) u_pick_lo (
        .i_req (w_lo_req),
        .i_ptr (r_ptr_lo),
        .o_gnt (w_lo_gnt),
        .o_idx (w_lo_idx),
        .o_any (w_lo_any)
    );

    // High class wins unless it has starved a waiting normal writer.
    assign w_use_hi  = w_hi_any && ((r_starve_cnt < STARVE_LIM8) || !w_lo_any);
    assign w_win_idx = w_use_hi ? w_hi_idx : w_lo_idx;
    assign w_win_any = w_use_hi ? w_hi_any : w_lo_any;
    assign w_win     = w_req[w_win_idx];

    assign w_free = !r_wvalid || i_wready;

    // A drain cycle is always a load, never a merge. A non-matching winner
    // against a stalled register simply waits: nobody else is taken instead.
    assign w_load   = rstn && w_free && w_win_any;
    assign w_merge  = rstn && r_wvalid && !i_wready && w_win_any &&
                      (w_win.addr == r_waddr);
    assign w_accept = w_load || w_merge;

    assign o_req_ready = w_accept ? (w_use_hi ? w_hi_gnt : w_lo_gnt) : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wvalid      <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_wport       <= '0;
            r_merge_count <= '0;
        end else begin
            if (w_load) begin
                r_wvalid <= 1'b1;
                r_waddr  <= w_win.addr;
                r_wdata  <= w_win.data;
                r_wstrb  <= w_win.strb;
            end else if (w_merge) begin
                r_wdata  <= rw_merge_bytes(r_wdata, w_win.data, w_win.strb);
                r_wstrb  <= r_wstrb | w_win.strb;
                if (r_merge_count != '1) begin
                    r_merge_count <= r_merge_count + 32'd1;
                end
            end else if (r_wvalid && i_wready) begin
                r_wvalid <= 1'b0;
            end
            if (w_accept) begin
                r_wport <= w_win_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ptr_hi     <= '0;
            r_ptr_lo     <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (w_accept) begin
                if (w_use_hi) begin
                    r_ptr_hi <= w_win_idx + PW'(1);
                end else begin
                    r_ptr_lo <= w_win_idx + PW'(1);
                end
            end
            if (!w_lo_any) begin
                r_starve_cnt <= '0;
            end else if (w_accept && !w_use_hi) begin
                r_starve_cnt <= '0;
            end else if (w_accept && w_use_hi && (r_starve_cnt != 8'hFF)) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end
    end

    assign o_wvalid      = r_wvalid;
    assign o_waddr       = r_waddr;
    assign o_wdata       = r_wdata;
    assign o_wstrb       = r_wstrb;
    assign o_wport       = r_wport;
    assign o_merge_count = r_merge_count;

endmodule
